// File: rtl/mca_dma_arb.sv
`default_nettype none
// ============================================================================
// Module   : mca_dma_arb
// Purpose  : Micro Channel style DMA channel arbiter. Takes a DMA request from
//            the DSP and competes on the ARB[3:0] bus with its local
//            arbitration level. When it wins, it holds the bus for one
//            transfer or for a burst and acknowledges the DSP with dack_l.
//            An optional fairness hold stops the channel from re-requesting
//            until every other requester has been served.
// Ports    : clk14        - 14.318 MHz system clock; all state on rising edge
//            chreset_l    - asynchronous active-low channel reset
//            arb_level    - local arbitration level, 4'hF = channel disabled
//            burst_en     - 1 = burst tenure, 0 = one transfer per grant
//            fair_en      - 1 = fairness hold after each release
//            dreq         - DMA request from the DSP (async)
//            arb_grant_l  - ARB/GNT#: high = arbitration, low = grant (async)
//            arb_in       - sensed ARB[3:0] bus value
//            arb_oe       - per-bit open-collector pull-down enable for ARB
//            preempt_in   - sensed PREEMPT# line (async)
//            preempt_oe   - pulls PREEMPT# low
//            burst_oe     - pulls BURST# low
//            cmd          - bus CMD#, active low (async)
//            tc_l         - terminal count, active low
//            dack_l       - DMA acknowledge to the DSP, active low
//            owner        - 1 while this channel owns the bus
// Revision : 1.0 - initial release
// ============================================================================
module mca_dma_arb #(
    parameter int BURST_MAX   = 16,   // transfers per burst tenure, 1..255
    parameter int SYNC_STAGES = 2     // synchronizer depth, >= 1
) (
    input  logic       clk14,
    input  logic       chreset_l,
    input  logic [3:0] arb_level,
    input  logic       burst_en,
    input  logic       fair_en,
    input  logic       dreq,
    input  logic       arb_grant_l,
    input  logic [3:0] arb_in,
    output logic [3:0] arb_oe,
    input  logic       preempt_in,
    output logic       preempt_oe,
    output logic       burst_oe,
    input  logic       cmd,
    input  logic       tc_l,
    output logic       dack_l,
    output logic       owner
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_burst_max = 8'(BURST_MAX);
    // Synchronizer lane order is {cmd, preempt_in, arb_grant_l, dreq}; the
    // reset value puts every lane at its inactive level.
    localparam logic [3:0] c_sync_rst  = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ARB  = 3'd2,
        ST_OWN  = 3'd3,
        ST_REL  = 3'd4,
        ST_FAIR = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];

    logic       grant_prev_q, grant_prev_d;
    logic       cmd_prev_q,   cmd_prev_d;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;

    logic       arb_phase_q,  arb_phase_d;
    logic       preempt_oe_q, preempt_oe_d;
    logic       burst_oe_q,   burst_oe_d;
    logic       dack_l_q,     dack_l_d;
    logic       owner_q,      owner_d;

    logic [3:0] w_sync_s;
    logic       w_dreq_s;
    logic       w_grant_s;
    logic       w_preempt_s;
    logic       w_cmd_s;
    logic       w_grant_fall;
    logic       w_grant_rise;
    logic       w_cmd_fall;
    logic       w_disabled;
    logic       w_win;
    logic [7:0] w_count_inc;
    logic       w_burst_stop;
    logic [3:0] w_arb_drive;
    logic       w_backoff;

    // ------------------------------------------------------------------------
    // Synchronized views of the asynchronous bus inputs
    // ------------------------------------------------------------------------
    assign w_sync_s    = sync_q[SYNC_STAGES-1];
    assign w_dreq_s    = w_sync_s[0];
    assign w_grant_s   = w_sync_s[1];
    assign w_preempt_s = w_sync_s[2];
    assign w_cmd_s     = w_sync_s[3];

    // Edges are taken between the synchronized value and its copy from the
    // previous clock, so every decision is made on clean, settled levels.
    assign w_grant_fall = grant_prev_q & ~w_grant_s;
    assign w_grant_rise = ~grant_prev_q & w_grant_s;
    assign w_cmd_fall   = cmd_prev_q & ~w_cmd_s;

    assign w_disabled   = (arb_level == 4'hF);
    // arb_in is sampled raw: by the time grant falls the ARB lines have long
    // since settled, and the synchronized grant edge is already late enough.
    assign w_win        = (arb_in == arb_level);
    assign w_count_inc  = count_q + 8'd1;

    // A burst ends on terminal count, withdrawn request, full burst or
    // another requester pulling PREEMPT#. The count saturates at
    // c_burst_max by leaving OWN, so the 8-bit counter never wraps.
    assign w_burst_stop = ~tc_l | ~w_dreq_s | (w_count_inc >= c_burst_max)
                        | ~w_preempt_s;

    // ------------------------------------------------------------------------
    // ARB[3:0] driver: MSB-first distributed compare. We drive every bit where
    // our level is 0 until we see a higher bit where we wanted 1 but some
    // other agent pulled the line to 0; from there down we back off.
    // ------------------------------------------------------------------------
    always_comb begin
        w_backoff   = 1'b0;
        w_arb_drive = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            w_arb_drive[i] = ~arb_level[i] & ~w_backoff;
            w_backoff      = w_backoff | (arb_level[i] & ~arb_in[i]);
        end
    end

    assign arb_oe = arb_phase_q ? w_arb_drive : 4'b0000;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        sync_d[0] = {cmd, preempt_in, arb_grant_l, dreq};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        grant_prev_d = w_grant_s;
        cmd_prev_d   = w_cmd_s;
        state_d      = state_q;
        count_d      = count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_dreq_s && !w_disabled) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (w_disabled || !w_dreq_s) begin
                    state_d = ST_IDLE;
                end else if (w_grant_s) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (w_disabled) begin
                    state_d = ST_IDLE;
                end else if (w_grant_fall) begin
                    if (w_win) begin
                        // A win with the request already gone still has to
                        // hand the bus back through REL.
                        count_d = 8'd0;
                        state_d = w_dreq_s ? ST_OWN : ST_REL;
                    end else begin
                        // Lost: keep PREEMPT# asserted and retry at the next
                        // arbitration phase.
                        state_d = ST_REQ;
                    end
                end
            end

            ST_OWN: begin
                // arb_level is deliberately ignored here; a disable lands on
                // the next pass through IDLE.
                if (w_grant_rise) begin
                    // Bus taken away by the central arbiter.
                    state_d = ST_REL;
                end else if (w_cmd_fall) begin
                    count_d = w_count_inc;
                    if (!burst_en || w_burst_stop) begin
                        state_d = ST_REL;
                    end
                end
            end

            ST_REL: begin
                state_d = fair_en ? ST_FAIR : ST_IDLE;
            end

            ST_FAIR: begin
                // PREEMPT# high means no other agent is still waiting.
                if (w_preempt_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the bus drivers and
        // dack_l come straight off flops and cannot glitch on state decode.
        arb_phase_d  = (state_d == ST_ARB);
        preempt_oe_d = (state_d == ST_REQ) || (state_d == ST_ARB);
        dack_l_d     = (state_d != ST_OWN);
        owner_d      = (state_d == ST_OWN);
        burst_oe_d   = (state_d == ST_OWN) && burst_en;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk14 or negedge chreset_l) begin
        if (!chreset_l) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= c_sync_rst;
            end
            grant_prev_q <= 1'b1;
            cmd_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            count_q      <= 8'd0;
            arb_phase_q  <= 1'b0;
            preempt_oe_q <= 1'b0;
            burst_oe_q   <= 1'b0;
            dack_l_q     <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            grant_prev_q <= grant_prev_d;
            cmd_prev_q   <= cmd_prev_d;
            state_q      <= state_d;
            count_q      <= count_d;
            arb_phase_q  <= arb_phase_d;
            preempt_oe_q <= preempt_oe_d;
            burst_oe_q   <= burst_oe_d;
            dack_l_q     <= dack_l_d;
            owner_q      <= owner_d;
        end
    end

    assign preempt_oe = preempt_oe_q;
    assign burst_oe   = burst_oe_q;
    assign dack_l     = dack_l_q;
    assign owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mca_dma_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mca_dma_arb
// Purpose  : Self-checking bench for mca_dma_arb. A vector table exercises
//            the ARB[3:0] distributed compare, hand-written sequences cover
//            fairness, disable, bus take-away and reset, and randomized
//            tenures are checked against a transaction-level model
//            (arbitration winner = lowest level, transfers per tenure =
//            earliest of burst limit / terminal count / preemption).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mca_dma_arb;

    localparam int BURST_MAX   = 4;
    localparam int SYNC_STAGES = 2;

    logic       clk14 = 1'b0;
    logic       chreset_l;
    logic [3:0] arb_level;
    logic       burst_en;
    logic       fair_en;
    logic       dreq;
    logic       arb_grant_l;
    logic [3:0] arb_in;
    logic [3:0] arb_oe;
    logic       preempt_in;
    logic       preempt_oe;
    logic       burst_oe;
    logic       cmd;
    logic       tc_l;
    logic       dack_l;
    logic       owner;

    // Another agent pulling PREEMPT#; the line is wired-AND with our driver.
    logic       comp_preempt;
    assign preempt_in = ~(preempt_oe | comp_preempt);

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] lvl;
        logic [3:0] bus;
        logic [3:0] oe;
    } arb_vec_t;

    arb_vec_t vecs [12];

    always #35 clk14 = ~clk14;

    mca_dma_arb #(
        .BURST_MAX   (BURST_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk14       (clk14),
        .chreset_l   (chreset_l),
        .arb_level   (arb_level),
        .burst_en    (burst_en),
        .fair_en     (fair_en),
        .dreq        (dreq),
        .arb_grant_l (arb_grant_l),
        .arb_in      (arb_in),
        .arb_oe      (arb_oe),
        .preempt_in  (preempt_in),
        .preempt_oe  (preempt_oe),
        .burst_oe    (burst_oe),
        .cmd         (cmd),
        .tc_l        (tc_l),
        .dack_l      (dack_l),
        .owner       (owner)
    );

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk14);
        #1;
    endtask

    // Bit i is driven when our level has a 0 there and, on every higher bit,
    // the bus never showed 0 where we wanted 1.
    function automatic logic [3:0] exp_oe(input logic [3:0] lvl, input logic [3:0] bus);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (!lvl[i] && (((lvl >> (i + 1)) & ~(bus >> (i + 1))) == 4'b0000)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // One arbitration phase against an optional competitor (4'hF = none).
    // The settled bus carries the lowest competing level.
    task automatic arbitrate(input logic [3:0] lvl, input logic [3:0] comp, output bit won);
        logic [3:0] bus;
        arb_grant_l = 1'b1;
        tick(4);
        bus    = (comp < lvl) ? comp : lvl;
        arb_in = bus;
        #1;
        check("arb_oe", 8'(arb_oe), 8'(exp_oe(lvl, bus)));
        check("arb_preempt_oe", 8'(preempt_oe), 8'd1);
        arb_grant_l = 1'b0;
        tick(5);
        arb_in = 4'hF;
        won    = (bus == lvl);
    endtask

    // One bus cycle: CMD# low, optionally with terminal count or a competing
    // PREEMPT# that stays asserted until the end of the tenure.
    task automatic cmd_pulse(input bit tc, input bit pre);
        if (pre) comp_preempt = 1'b1;
        cmd  = 1'b0;
        tc_l = ~tc;
        tick(4);
        cmd  = 1'b1;
        tc_l = 1'b1;
        tick(3);
    endtask

    // Full tenure from request to idle, with expectations from the model.
    task automatic tenure(input logic [3:0] lvl, input logic [3:0] comp, input bit burst,
                          input bit fair, input int tc_at, input int pre_at);
        bit won;
        int n_exp;
        arb_level = lvl;
        burst_en  = burst;
        fair_en   = fair;
        dreq      = 1'b1;
        tick(4);
        check("req_preempt_oe", 8'(preempt_oe), 8'd1);
        arbitrate(lvl, comp, won);
        if (!won) begin
            check("lost_dack_l", 8'(dack_l), 8'd1);
            check("lost_preempt_oe", 8'(preempt_oe), 8'd1);
            arbitrate(lvl, 4'hF, won);
        end
        check("own_dack_l", 8'(dack_l), 8'd0);
        check("own_owner", 8'(owner), 8'd1);
        check("own_burst_oe", 8'(burst_oe), 8'(burst));
        check("own_preempt_oe", 8'(preempt_oe), 8'd0);
        check("own_arb_oe", 8'(arb_oe), 8'd0);

        if (!burst) begin
            n_exp = 1;
        end else begin
            n_exp = BURST_MAX;
            if (tc_at > 0 && tc_at < n_exp) n_exp = tc_at;
            if (pre_at > 0 && pre_at < n_exp) n_exp = pre_at;
        end

        for (int k = 1; k <= n_exp; k++) begin
            cmd_pulse(k == tc_at, (pre_at != 0) && (k >= pre_at));
            if (k < n_exp) begin
                check($sformatf("mid_dack_l_%0d", k), 8'(dack_l), 8'd0);
                check($sformatf("mid_burst_oe_%0d", k), 8'(burst_oe), 8'(burst));
            end else begin
                check($sformatf("end_dack_l_after_%0d", k), 8'(dack_l), 8'd1);
                check("end_owner", 8'(owner), 8'd0);
                check("end_burst_oe", 8'(burst_oe), 8'd0);
            end
        end

        dreq         = 1'b0;
        comp_preempt = 1'b0;
        tick(8);
        check("idle_preempt_oe", 8'(preempt_oe), 8'd0);
        check("idle_dack_l", 8'(dack_l), 8'd1);
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #(70 * 50000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        bit         won;
        bit         quiet_bad;
        logic [3:0] r_lvl;
        logic [3:0] r_comp;

        vecs[0]  = '{4'h5, 4'hF, 4'hA};
        vecs[1]  = '{4'h5, 4'h5, 4'hA};
        vecs[2]  = '{4'h5, 4'h3, 4'h8};
        vecs[3]  = '{4'h5, 4'h4, 4'hA};
        vecs[4]  = '{4'h0, 4'h0, 4'hF};
        vecs[5]  = '{4'h8, 4'h0, 4'h0};
        vecs[6]  = '{4'h8, 4'h8, 4'h7};
        vecs[7]  = '{4'h9, 4'h8, 4'h6};
        vecs[8]  = '{4'h6, 4'h2, 4'h8};
        vecs[9]  = '{4'h6, 4'h4, 4'h8};
        vecs[10] = '{4'hE, 4'hE, 4'h1};
        vecs[11] = '{4'hE, 4'h6, 4'h0};

        chreset_l    = 1'b0;
        arb_level    = 4'h5;
        burst_en     = 1'b0;
        fair_en      = 1'b0;
        dreq         = 1'b0;
        arb_grant_l  = 1'b0;
        arb_in       = 4'hF;
        cmd          = 1'b1;
        tc_l         = 1'b1;
        comp_preempt = 1'b0;

        // Reset state
        tick(3);
        check("rst_arb_oe", 8'(arb_oe), 8'd0);
        check("rst_preempt_oe", 8'(preempt_oe), 8'd0);
        check("rst_burst_oe", 8'(burst_oe), 8'd0);
        check("rst_dack_l", 8'(dack_l), 8'd1);
        check("rst_owner", 8'(owner), 8'd0);
        chreset_l = 1'b1;
        tick(3);

        // Distributed compare table, DUT parked in the arbitration phase
        dreq = 1'b1;
        tick(4);
        arb_grant_l = 1'b1;
        tick(4);
        for (int v = 0; v < 12; v++) begin
            arb_level = vecs[v].lvl;
            arb_in    = vecs[v].bus;
            #1;
            check($sformatf("arb_vec%0d", v), 8'(arb_oe), 8'(vecs[v].oe));
        end
        arb_level   = 4'h5;
        arb_in      = 4'hF;
        dreq        = 1'b0;
        arb_grant_l = 1'b0;
        tick(8);
        check("table_exit_preempt_oe", 8'(preempt_oe), 8'd0);

        // Lone requester, single transfer
        tenure(4'h5, 4'hF, 1'b0, 1'b0, 0, 0);
        // Competitor at level 3 wins first, we win the retry
        tenure(4'h5, 4'h3, 1'b0, 1'b0, 0, 0);
        // Full burst, then burst cut short by terminal count and by preemption
        tenure(4'h5, 4'hF, 1'b1, 1'b0, 0, 0);
        tenure(4'h5, 4'hF, 1'b1, 1'b0, 2, 0);
        tenure(4'h9, 4'hF, 1'b1, 1'b0, 0, 3);

        // Fairness hold while another agent keeps PREEMPT# low
        arb_level = 4'h5;
        burst_en  = 1'b0;
        fair_en   = 1'b1;
        dreq      = 1'b1;
        tick(4);
        arbitrate(4'h5, 4'hF, won);
        check("fair_own_dack_l", 8'(dack_l), 8'd0);
        cmd_pulse(1'b0, 1'b1);
        check("fair_rel_dack_l", 8'(dack_l), 8'd1);
        tick(10);
        check("fair_hold_preempt_oe", 8'(preempt_oe), 8'd0);
        comp_preempt = 1'b0;
        tick(6);
        check("fair_exit_req_preempt_oe", 8'(preempt_oe), 8'd1);
        dreq    = 1'b0;
        fair_en = 1'b0;
        tick(6);
        check("fair_idle_preempt_oe", 8'(preempt_oe), 8'd0);

        // Disable while requesting drops back to idle
        dreq = 1'b1;
        tick(4);
        check("dis_req_preempt_oe", 8'(preempt_oe), 8'd1);
        arb_level = 4'hF;
        tick(2);
        check("dis_idle_preempt_oe", 8'(preempt_oe), 8'd0);

        // Disabled channel never drives anything
        quiet_bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c % 5 == 0) arb_grant_l = ~arb_grant_l;
            tick(1);
            if (arb_oe != 4'h0 || preempt_oe || burst_oe || !dack_l || owner) quiet_bad = 1'b1;
        end
        check("disabled_quiet", 8'(quiet_bad), 8'd0);
        dreq        = 1'b0;
        arb_grant_l = 1'b0;
        arb_level   = 4'h5;
        tick(6);

        // Bus taken away mid-burst
        burst_en = 1'b1;
        dreq     = 1'b1;
        tick(4);
        arbitrate(4'h5, 4'hF, won);
        check("take_own_dack_l", 8'(dack_l), 8'd0);
        arb_grant_l = 1'b1;
        tick(4);
        check("take_rel_dack_l", 8'(dack_l), 8'd1);
        check("take_rel_owner", 8'(owner), 8'd0);
        dreq        = 1'b0;
        arb_grant_l = 1'b0;
        tick(8);
        check("take_idle_preempt_oe", 8'(preempt_oe), 8'd0);

        // Reset mid-tenure releases all drivers without a clock edge
        dreq = 1'b1;
        tick(4);
        arbitrate(4'h5, 4'hF, won);
        check("rst_own_dack_l", 8'(dack_l), 8'd0);
        check("rst_own_burst_oe", 8'(burst_oe), 8'd1);
        #5;
        chreset_l = 1'b0;
        #1;
        check("rst_mid_dack_l", 8'(dack_l), 8'd1);
        check("rst_mid_burst_oe", 8'(burst_oe), 8'd0);
        check("rst_mid_owner", 8'(owner), 8'd0);
        dreq = 1'b0;
        tick(2);
        chreset_l = 1'b1;
        tick(6);
        check("rst_after_dack_l", 8'(dack_l), 8'd1);
        check("rst_after_preempt_oe", 8'(preempt_oe), 8'd0);

        // Randomized tenures against the transaction model
        for (int it = 0; it < 20; it++) begin
            r_lvl = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 1) == 1) begin
                r_comp = 4'($urandom_range(0, 14));
                if (r_comp == r_lvl) r_comp = 4'hF;
            end else begin
                r_comp = 4'hF;
            end
            tenure(r_lvl, r_comp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mca_dma_arb.md
MCA_DMA_ARB -- requirements
Module: mca_dma_arb

Interface
REQ-001 Parameter BURST_MAX, default 16: max transfers per burst tenure (1..255).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on async bus inputs.
REQ-003 clk14  in  1  14.318 MHz system clock; all state on rising edge.
REQ-004 chreset_l  in  1  asynchronous, active-low reset.
REQ-005 arb_level  in  4  local arbitration level from POS; 4'hF = channel disabled.
REQ-006 burst_en  in  1  1 = burst tenure, 0 = single transfer per grant.
REQ-007 fair_en  in  1  1 = fairness hold after release.
REQ-008 dreq  in  1  DMA request from DSP, active-high, async.
REQ-009 arb_grant_l  in  1  bus ARB/GNT#; high = arbitration phase, low = grant; async.
REQ-010 arb_in  in  4  sensed ARB[3:0] bus value.
REQ-011 arb_oe  out  4  bit i = 1 pulls ARB[i] low (open-collector enable).
REQ-012 preempt_in  in  1  sensed PREEMPT# bus line, async.
REQ-013 preempt_oe  out  1  1 pulls PREEMPT# low.
REQ-014 burst_oe  out  1  1 pulls BURST# low.
REQ-015 cmd  in  1  bus CMD#, active-low; async.
REQ-016 tc_l  in  1  terminal count, active-low.
REQ-017 dack_l  out  1  DMA acknowledge to DSP, active-low.
REQ-018 owner  out  1  status: 1 while channel owns the bus.

Function
REQ-019 dreq, arb_grant_l, preempt_in, cmd SHALL pass through SYNC_STAGES flops; "_s" below = synchronized; arb_in and tc_l used unsynchronized only where stated.
REQ-020 States: IDLE, REQ, ARB, OWN, REL, FAIR; one-hot or binary, encoding free.
REQ-021 IDLE -> REQ when dreq_s=1 and arb_level!=4'hF; else stay; all outputs inactive.
REQ-022 REQ: preempt_oe=1; -> ARB when arb_grant_l_s=1; -> IDLE if dreq_s=0 before ARB.
REQ-023 ARB: preempt_oe=1; arb_oe[i] = ~arb_level[i] AND no j>i with arb_level[j]=1 and arb_in[j]=0 (combinational MSB-first compare).
REQ-024 ARB decision on the clock where arb_grant_l_s goes 1->0: win iff arb_in == arb_level sampled that edge.
REQ-025 Win with dreq_s=1 -> OWN; win with dreq_s=0 -> REL; loss -> REQ (preempt_oe held, retry next arbitration).
REQ-026 OWN: arb_oe=0, preempt_oe=0, dack_l=0, owner=1, burst_oe=burst_en; transfer counter cleared on entry.
REQ-027 Each cmd_s 1->0 edge in OWN = end of one transfer: counter +1, tc_l sampled at that edge.
REQ-028 Single mode: first transfer end -> REL.
REQ-029 Burst mode: at transfer end -> REL if tc_l=0, dreq_s=0, counter==BURST_MAX, or preempt_in_s=0 (another requester); else stay in OWN.
REQ-030 Burst: burst_oe drops on the same edge a release condition is detected; counter 8 bits, no wrap (REL before overflow).
REQ-031 REL: dack_l=1, burst_oe=0, owner=0 for exactly one clock; -> FAIR if fair_en=1, else IDLE.
REQ-032 FAIR: all outputs inactive; -> IDLE on first clock with preempt_in_s=1; dreq ignored while in FAIR.
REQ-033 arb_level changed to 4'hF in REQ/ARB -> IDLE next clock; in OWN takes effect at next REL.
REQ-034 arb_grant_l_s rising while in OWN (bus taken away) -> REL immediately.

Reset
REQ-035 chreset_l=0 asynchronously forces IDLE, synchronizers to inactive levels (dreq 0, others 1), counter 0; outputs arb_oe=0, preempt_oe=0, burst_oe=0, dack_l=1, owner=0.
REQ-036 Reset mid-tenure releases all bus drivers within the reset assertion, no glitch-low on dack_l after release.

Verification
REQ-037 arb_level=4'h5, dreq=1, lone requester -> preempt_oe=1, arb_oe=4'b1010, arb_in=4'h5, grant low -> dack_l=0, one cmd cycle -> dack_l=1, state IDLE.
REQ-038 arb_level=4'h5, competitor drives level 4'h3 -> arb_oe drops to 4'b1000 after bit2 loss, arb_in=4'h3, loss, preempt_oe stays 1, wins next arbitration.
REQ-039 burst_en=1, BURST_MAX=4, dreq held -> burst_oe=1, four cmd cycles then REL; tc_l=0 on 2nd cycle -> REL after 2.
REQ-040 fair_en=1, preempt_in held low after REL -> stays in FAIR with dreq=1; preempt_in high -> IDLE then REQ.
REQ-041 arb_level=4'hF with dreq=1 -> no output ever asserts.
REQ-042 chreset_l pulsed low in OWN -> dack_l=1, burst_oe=0 immediately; IDLE after release.
